// File: rtl/door_pkg.sv
// Shared types for the garage-door motion sequencer: state encoding, motor
// commands and run direction.
package door_pkg;

  typedef enum logic [2:0] {
    IDLE_MID = 3'd0,
    CLOSED   = 3'd1,
    OPEN     = 3'd2,
    DEAD_UP  = 3'd3,
    DEAD_DN  = 3'd4,
    OPENING  = 3'd5,
    CLOSING  = 3'd6,
    FAULT    = 3'd7
  } door_state_t;

  localparam logic [1:0] MOTOR_STOP = 2'b00;
  localparam logic [1:0] MOTOR_UP   = 2'b01;
  localparam logic [1:0] MOTOR_DOWN = 2'b10;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // The motor only runs in the two travel states; everything else holds it off.
  function automatic logic [1:0] motor_for(input door_state_t s);
    case (s)
      OPENING: motor_for = MOTOR_UP;
      CLOSING: motor_for = MOTOR_DOWN;
      default: motor_for = MOTOR_STOP;
    endcase
  endfunction

endpackage

// File: rtl/door_timer.sv
// Saturating cycle counter with synchronous clear; tc_o flags the last counted
// cycle (count == TERM-1) while enabled. TERM of 0 disables the terminal count.
module door_timer #(
  parameter int          CW   = 31,
  parameter int unsigned TERM = 1
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CW-1:0] LAST   = CW'(TERM - 1);
  localparam bit            ACTIVE = (TERM != 0);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign tc_o = ACTIVE && en_i && (cnt_q == LAST);

endmodule

// File: rtl/door_motion_sequencer.sv
// Garage-door motor sequencer: dead time before every run, travel watchdog,
// obstruction auto-reverse and auto-close. All outputs registered.
module door_motion_sequencer
  import door_pkg::*;
#(
  parameter int unsigned TRAVEL_MAX = 500000000,
  parameter int unsigned AUTO_CLOSE = 1500000000,
  parameter int unsigned DEAD_TIME  = 2500000,
  parameter int          CW         = 31
) (
  input  logic       Clock,
  input  logic       ResetN,
  input  logic       Bo,
  input  logic       UpperLS,
  input  logic       LowerLS,
  input  logic       Obstruct,
  output logic [1:0] M,
  output logic       Fault,
  output logic [2:0] State
);

  door_state_t state_q, state_d;
  dir_t        dir_q, dir_d;
  logic [1:0]  m_q;
  logic        fault_q;

  logic travel_tc, close_tc, dead_tc;
  logic enter, restart;
  logic travel_en, close_en, dead_en;

  assign travel_en = (state_q == OPENING) || (state_q == CLOSING);
  assign close_en  = (state_q == OPEN) && !Obstruct;
  assign dead_en   = (state_q == DEAD_UP) || (state_q == DEAD_DN);
  assign enter     = (state_d != state_q);
  // A broken beam during the closing dead time re-arms the full dead time.
  assign restart   = (state_q == DEAD_DN) && Obstruct;

  always_comb begin
    state_d = state_q;
    if (UpperLS && LowerLS) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        CLOSED:   if (Bo) state_d = DEAD_UP;
        OPEN: begin
          if (Bo)                       state_d = DEAD_DN;
          else if (!Obstruct && close_tc) state_d = DEAD_DN;
        end
        IDLE_MID: if (Bo) state_d = (dir_q == DIR_DOWN) ? DEAD_UP : DEAD_DN;
        DEAD_UP: begin
          if (Bo)           state_d = IDLE_MID;
          else if (dead_tc) state_d = OPENING;
        end
        DEAD_DN: begin
          if (Obstruct)     state_d = DEAD_DN;
          else if (Bo)      state_d = IDLE_MID;
          else if (dead_tc) state_d = CLOSING;
        end
        OPENING: begin
          if (travel_tc)    state_d = FAULT;
          else if (UpperLS) state_d = OPEN;
          else if (Bo)      state_d = IDLE_MID;
        end
        CLOSING: begin
          if (travel_tc)     state_d = FAULT;
          else if (Obstruct) state_d = DEAD_UP;
          else if (LowerLS)  state_d = CLOSED;
          else if (Bo)       state_d = IDLE_MID;
        end
        FAULT:   state_d = FAULT;
        default: state_d = FAULT;
      endcase
    end
  end

  always_comb begin
    dir_d = dir_q;
    if (state_d == OPENING)      dir_d = DIR_UP;
    else if (state_d == CLOSING) dir_d = DIR_DOWN;
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q <= LowerLS ? CLOSED : (UpperLS ? OPEN : IDLE_MID);
      dir_q   <= DIR_DOWN;
      m_q     <= MOTOR_STOP;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      m_q     <= motor_for(state_d);
      fault_q <= (state_d == FAULT);
    end
  end

  door_timer #(.CW(CW), .TERM(TRAVEL_MAX)) u_travel (
    .clk_i (Clock),
    .clr_i (!ResetN || enter),
    .en_i  (travel_en),
    .tc_o  (travel_tc)
  );

  door_timer #(.CW(CW), .TERM(AUTO_CLOSE)) u_close (
    .clk_i (Clock),
    .clr_i (!ResetN || enter || ((state_q == OPEN) && Obstruct)),
    .en_i  (close_en),
    .tc_o  (close_tc)
  );

  door_timer #(.CW(CW), .TERM(DEAD_TIME)) u_dead (
    .clk_i (Clock),
    .clr_i (!ResetN || enter || restart),
    .en_i  (dead_en),
    .tc_o  (dead_tc)
  );

  assign M     = m_q;
  assign Fault = fault_q;
  assign State = state_q;

endmodule

// File: tb/tb_door_motion_sequencer.sv
// Directed bench for door_motion_sequencer with short timers
// (TRAVEL_MAX=20, AUTO_CLOSE=10, DEAD_TIME=2).
module tb_door_motion_sequencer;
  import door_pkg::*;

  logic       Clock = 1'b0;
  logic       ResetN, Bo, UpperLS, LowerLS, Obstruct;
  logic [1:0] M;
  logic       Fault;
  logic [2:0] State;

  int checks = 0;
  int errors = 0;

  door_motion_sequencer #(
    .TRAVEL_MAX (20),
    .AUTO_CLOSE (10),
    .DEAD_TIME  (2),
    .CW         (8)
  ) dut (
    .Clock    (Clock),
    .ResetN   (ResetN),
    .Bo       (Bo),
    .UpperLS  (UpperLS),
    .LowerLS  (LowerLS),
    .Obstruct (Obstruct),
    .M        (M),
    .Fault    (Fault),
    .State    (State)
  );

  always #5 Clock = ~Clock;

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic pulse_bo();
    Bo = 1'b1;
    step(1);
    Bo = 1'b0;
  endtask

  task automatic check(input string tag, input door_state_t es, input logic [1:0] em,
                       input logic ef);
    checks += 3;
    assert (State === es) else begin
      errors++;
      $error("FAIL %s state got %0d want %0d", tag, State, es);
    end
    assert (M === em) else begin
      errors++;
      $error("FAIL %s M got %b want %b", tag, M, em);
    end
    assert (Fault === ef) else begin
      errors++;
      $error("FAIL %s Fault got %b want %b", tag, Fault, ef);
    end
  endtask

  // Motor watcher: never 11, and a direction change needs two stopped cycles.
  logic [1:0] last_run = 2'b00;
  int         stop_cnt = 0;
  always @(negedge Clock) begin
    checks++;
    assert (M !== 2'b11) else begin
      errors++;
      $error("FAIL motor_11 M got %b want not 11", M);
    end
    if (M == MOTOR_UP || M == MOTOR_DOWN) begin
      if (last_run != 2'b00 && M != last_run) begin
        checks++;
        assert (stop_cnt >= 2) else begin
          errors++;
          $error("FAIL reversal_gap stop cycles got %0d want >= 2", stop_cnt);
        end
      end
      last_run = M;
      stop_cnt = 0;
    end else begin
      stop_cnt++;
    end
  end

  initial begin
    ResetN = 1'b0; Bo = 1'b0; UpperLS = 1'b0; LowerLS = 1'b1; Obstruct = 1'b0;
    step(2);
    check("rst_closed", CLOSED, MOTOR_STOP, 1'b0);
    ResetN = 1'b1;

    // Open from closed: two dead cycles then run up until the upper switch.
    pulse_bo();
    LowerLS = 1'b0;
    check("t1_dead0", DEAD_UP, MOTOR_STOP, 1'b0);
    step(1); check("t1_dead1", DEAD_UP, MOTOR_STOP, 1'b0);
    step(1); check("t1_run", OPENING, MOTOR_UP, 1'b0);
    step(4); check("t1_run4", OPENING, MOTOR_UP, 1'b0);
    UpperLS = 1'b1;
    step(1); check("t1_open", OPEN, MOTOR_STOP, 1'b0);

    // Auto-close after 10 cycles, then obstruction reverses the close.
    step(9); check("t2_open9", OPEN, MOTOR_STOP, 1'b0);
    step(1); check("t2_autoclose", DEAD_DN, MOTOR_STOP, 1'b0);
    UpperLS = 1'b0;
    step(1); check("t2_dead1", DEAD_DN, MOTOR_STOP, 1'b0);
    step(1); check("t2_closing", CLOSING, MOTOR_DOWN, 1'b0);
    step(2);
    Obstruct = 1'b1;
    step(1); check("t2_reverse", DEAD_UP, MOTOR_STOP, 1'b0);
    Obstruct = 1'b0;
    step(1); check("t2_rdead1", DEAD_UP, MOTOR_STOP, 1'b0);
    step(1); check("t2_reopen", OPENING, MOTOR_UP, 1'b0);

    // Bo mid-close stops; next Bo reverses to opening.
    UpperLS = 1'b1;
    step(1); check("t3_open", OPEN, MOTOR_STOP, 1'b0);
    pulse_bo();
    UpperLS = 1'b0;
    check("t3_deaddn", DEAD_DN, MOTOR_STOP, 1'b0);
    step(2); check("t3_closing", CLOSING, MOTOR_DOWN, 1'b0);
    step(3);
    pulse_bo();
    check("t3_stop", IDLE_MID, MOTOR_STOP, 1'b0);
    step(2); check("t3_idle", IDLE_MID, MOTOR_STOP, 1'b0);
    pulse_bo();
    check("t3_deadup", DEAD_UP, MOTOR_STOP, 1'b0);
    step(2); check("t3_opening", OPENING, MOTOR_UP, 1'b0);

    // Travel watchdog: 20 cycles of running with no limit switch.
    step(19); check("t4_run19", OPENING, MOTOR_UP, 1'b0);
    step(1);  check("t4_fault", FAULT, MOTOR_STOP, 1'b1);
    pulse_bo();
    check("t4_bo_ignored", FAULT, MOTOR_STOP, 1'b1);
    step(3); check("t4_fault_hold", FAULT, MOTOR_STOP, 1'b1);
    ResetN = 1'b0;
    step(1); check("t4_reset_mid", IDLE_MID, MOTOR_STOP, 1'b0);
    ResetN = 1'b1;

    // Both limit switches: fault from a running state and from CLOSED.
    pulse_bo();
    check("t5_deadup", DEAD_UP, MOTOR_STOP, 1'b0);
    step(2); check("t5_opening", OPENING, MOTOR_UP, 1'b0);
    UpperLS = 1'b1; LowerLS = 1'b1;
    step(1); check("t5_both_run", FAULT, MOTOR_STOP, 1'b1);
    ResetN = 1'b0; UpperLS = 1'b0;
    step(1); check("t5_rst_closed", CLOSED, MOTOR_STOP, 1'b0);
    ResetN = 1'b1;
    UpperLS = 1'b1;
    step(1); check("t5_both_closed", FAULT, MOTOR_STOP, 1'b1);
    ResetN = 1'b0; UpperLS = 1'b0;
    step(1); check("t5_rst2", CLOSED, MOTOR_STOP, 1'b0);
    ResetN = 1'b1;

    // Bo during dead time cancels the run.
    pulse_bo();
    LowerLS = 1'b0;
    check("t6_deadup", DEAD_UP, MOTOR_STOP, 1'b0);
    pulse_bo();
    check("t6_cancel", IDLE_MID, MOTOR_STOP, 1'b0);
    pulse_bo();
    step(2); check("t6_opening", OPENING, MOTOR_UP, 1'b0);
    UpperLS = 1'b1;
    step(1); check("t6_open", OPEN, MOTOR_STOP, 1'b0);

    // Obstruction during closing dead time restarts the dead count.
    pulse_bo();
    UpperLS = 1'b0; Obstruct = 1'b1;
    step(3); check("t6_dd_hold", DEAD_DN, MOTOR_STOP, 1'b0);
    Obstruct = 1'b0;
    step(1); check("t6_dd_1", DEAD_DN, MOTOR_STOP, 1'b0);
    step(1); check("t6_closing", CLOSING, MOTOR_DOWN, 1'b0);
    step(2);
    Obstruct = 1'b1; LowerLS = 1'b1;
    step(1); check("t6_obs_over_ls", DEAD_UP, MOTOR_STOP, 1'b0);
    Obstruct = 1'b0;
    step(1); check("t6_rdead1", DEAD_UP, MOTOR_STOP, 1'b0);
    LowerLS = 1'b0;
    step(1); check("t6_reopen", OPENING, MOTOR_UP, 1'b0);

    // Obstruction in OPEN holds the auto-close counter at zero.
    UpperLS = 1'b1;
    step(1); check("t7_open", OPEN, MOTOR_STOP, 1'b0);
    Obstruct = 1'b1;
    step(15); check("t7_held", OPEN, MOTOR_STOP, 1'b0);
    Obstruct = 1'b0;
    step(9); check("t7_open9", OPEN, MOTOR_STOP, 1'b0);
    step(1); check("t7_autoclose", DEAD_DN, MOTOR_STOP, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
